vector_load_unit: RTL and testbench
===================================

# vector_load_unit

Fetches one 128-bit vector register's worth of data from the 32-bit data memory as four word reads. Writes each word into the register set one lane at a time. Sits directly upstream of the register set, driving its row/column write port (`writeAddressR`, `writeAddressC`, `writeData`, `writeEnable`, `mem_load_enable`). Accepts one load command from the decode/execute stage at a time and reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 16, word address width of the data memory
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  load command present
- `cmd_ready`  out  1  unit idle, can accept a command
- `cmd_addr`  in  ADDR_W  base word address
- `cmd_rd`  in  4  destination vector register
- `cmd_stride`  in  ADDR_W  word stride between lanes (only with `VLOAD_STRIDE_EN`)
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  memory word address
- `mem_gnt`  in  1  memory accepted request this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data word
- `writeEnable`  out  1  register set write strobe
- `mem_load_enable`  out  1  selects lane-write mode in register set
- `writeAddressR`  out  4  register row
- `writeAddressC`  out  2  lane/column
- `writeData`  out  128  `{96'b0, word}`
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse, all four lanes written

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid&&cmd_ready`, latch `cmd_addr`, `cmd_rd` (and `cmd_stride`), set `lane=0`, go to REQ.
- REQ:
  - `mem_req=1`, `mem_addr = base + lane*stride`, truncated mod 2^ADDR_W (wrap-around allowed).
  - Hold request and address until `mem_gnt`, then go to WAIT.
- WAIT:
  - On `mem_rvalid`, capture `mem_rdata` and go to WRITE.
  - `mem_rvalid` may arrive in the cycle immediately after the grant or any later cycle; no timeout.
- WRITE:
  - For exactly one cycle: `writeEnable=1`, `mem_load_enable=1`, `writeAddressR=rd`, `writeAddressC=lane`, `writeData={96'b0,word}`.
  - If `lane==3`, go to DONE; otherwise `lane+1` and go to REQ.
- DONE: `done=1` for one cycle, then IDLE.
- `busy=1` in every state except IDLE.
- `mem_rvalid` outside WAIT is ignored (stale responses after reset).
- `cmd_valid` outside IDLE is ignored. The upstream stage must hold the command until `cmd_ready`.
- Lane order is fixed 0,1,2,3. Only one memory request is outstanding at a time.

## Timing
- Reset values:
  - All registered outputs 0.
  - `writeAddressR=0`, `writeAddressC=0`, `writeData=0`.
  - `cmd_ready=1`, state IDLE, lane 0.
- `cmd_ready`, `mem_req`, `busy`, `writeEnable`, `done` decode from registered state with no combinational path from inputs.
- `mem_addr` and write-port outputs are registered.
- Minimum latency with `mem_gnt` held high and `mem_rvalid` one cycle after the grant:
  - Accept at edge 0; REQ in cycle 1; WAIT in cycle 2; WRITE in cycle 3.
  - Each lane takes 3 cycles, so the last write is in cycle 12 and `done` in cycle 13.
  - Next command can be accepted in cycle 14.
- Reset asserted mid-command: return to IDLE immediately, drop `mem_req`. A partially loaded register keeps the lanes already written.

## Configuration
- `VLOAD_STRIDE_EN` defined:
  - `cmd_stride` port present and latched at accept.
  - Lane addresses are `base + lane*stride`; stride 0 replicates one word into all lanes.
- Undefined:
  - No `cmd_stride` port.
  - Stride fixed to 1, so lanes read `base..base+3`.

## Structure
- Shared package `vload_pkg`:
  - State enum.
  - `VLOAD_LANES=4`, `WORD_W=32`, `VREG_W=128`, `LANE_W=2`, `VREG_ADDR_W=4`.
- Sub-module `vload_addr_gen`:
  - Base/stride/lane to `mem_addr`.
  - Stride multiply reduced to an add per lane (running address accumulator).

## Test plan
- Contiguous load, no stride:
  - Stimulus: `cmd_addr=0x0010`, `cmd_rd=5`, memory returns `0x11111111..0x44444444`, `mem_gnt=1`.
  - Response: reads 0x10–0x13; four writes with R=5, C=0..3, `writeData[31:0]` matching each word; `done` in cycle 13.
- Backpressure:
  - Stimulus: `mem_gnt` low 3 cycles per request, `mem_rvalid` delayed 2 cycles.
  - Response: `mem_addr` stable while waiting; writes still in lane order; `busy` high throughout.
- Address wrap:
  - Stimulus: `cmd_addr=0xFFFE`.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Stride (`VLOAD_STRIDE_EN`):
  - Stimulus A: `cmd_stride=4`, base 0x20. Response: addresses 0x20, 0x24, 0x28, 0x2C.
  - Stimulus B: stride 0. Response: four reads of the same address.
- Reset mid-load:
  - Stimulus: assert `reset` during WAIT of lane 2, then pulse a stale `mem_rvalid`.
  - Response: no further writes; `cmd_ready=1`; next command completes normally from lane 0.
- Command gating:
  - Stimulus: hold `cmd_valid=1` with new values during `busy`.
  - Response: only the latched command executes; new command accepted the cycle after `done`.

Source files
------------

// File: rtl/vload_pkg.sv
// -----------------------------------------------------------------------------
// vload_pkg
// Shared definitions for the vector load unit: FSM state encoding and the
// geometry of a vector register (4 lanes of 32-bit words = 128 bits).
// -----------------------------------------------------------------------------
package vload_pkg;

   localparam int VLOAD_LANES = 4;    // lanes per vector register
   localparam int WORD_W      = 32;   // data memory word width
   localparam int VREG_W      = 128;  // vector register width
   localparam int LANE_W      = 2;    // lane (column) index width
   localparam int VREG_ADDR_W = 4;    // vector register (row) index width

   // Index of the final lane; reaching it ends the command.
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VLOAD_LANES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WRITE,
      S_DONE
   } vload_state_e;

endpackage

// File: rtl/vload_addr_gen.sv
// -----------------------------------------------------------------------------
// vload_addr_gen
// Lane address generator for the vector load unit. Produces
// base + lane*stride (mod 2^ADDR_W) without a multiplier: the base is loaded
// when a command is accepted and the latched stride is added once per lane.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         accept a new command: addr <= base, stride latched
//   step         advance to the next lane: addr <= addr + stride
//   base         base word address of the command
//   stride       word stride between lanes
//   addr         registered memory word address for the current lane
// -----------------------------------------------------------------------------
module vload_addr_gen
   import vload_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      addr_d   = addr_q;
      stride_d = stride_q;
      if (load) begin
         addr_d   = base;
         stride_d = stride;
      end else if (step) begin
         // Natural truncation gives the required wrap-around at 2^ADDR_W.
         addr_d = addr_q + stride_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before the edge, independent of order.
      if (reset) begin
         addr_q   <= '0;
         stride_q <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
      end
   end

   assign addr = addr_q;

endmodule

// File: rtl/vector_load_unit.sv
// -----------------------------------------------------------------------------
// vector_load_unit
// Loads one 128-bit vector register from 32-bit data memory as four word
// reads (lanes 0..3), writing each word into the register set through its
// row/column lane-write port. One command at a time; 'done' pulses for one
// cycle once all four lanes are written.
//
// Build option: define VLOAD_STRIDE_EN to add the cmd_stride port (lane
// addresses base + lane*stride). Without it the stride is fixed to 1.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_addr, cmd_rd    base word address, destination vector register
//   cmd_stride          lane stride (VLOAD_STRIDE_EN only)
//   mem_req/addr/gnt    memory read request, held until granted
//   mem_rvalid/rdata    memory read response
//   writeEnable, mem_load_enable, writeAddressR, writeAddressC, writeData
//                       register-set lane write port
//   busy, done          command in progress, completion pulse
// -----------------------------------------------------------------------------
module vector_load_unit
   import vload_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [VREG_ADDR_W-1:0] cmd_rd,
`ifdef VLOAD_STRIDE_EN
   input  logic [ADDR_W-1:0]      cmd_stride,
`endif
   output logic                   mem_req,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [WORD_W-1:0]      mem_rdata,
   output logic                   writeEnable,
   output logic                   mem_load_enable,
   output logic [VREG_ADDR_W-1:0] writeAddressR,
   output logic [LANE_W-1:0]      writeAddressC,
   output logic [VREG_W-1:0]      writeData,
   output logic                   busy,
   output logic                   done
);

   vload_state_e           state_q, state_d;
   logic [LANE_W-1:0]      lane_q, lane_d;
   logic [VREG_ADDR_W-1:0] rd_q, rd_d;
   logic [WORD_W-1:0]      word_q, word_d;
   logic [VREG_ADDR_W-1:0] wr_row_q, wr_row_d;
   logic [LANE_W-1:0]      wr_col_q, wr_col_d;

   logic              addr_load;
   logic              addr_step;
   logic [ADDR_W-1:0] stride_in;

`ifdef VLOAD_STRIDE_EN
   assign stride_in = cmd_stride;
`else
   assign stride_in = ADDR_W'(1);
`endif

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      rd_d      = rd_q;
      word_d    = word_q;
      wr_row_d  = wr_row_q;
      wr_col_d  = wr_col_q;
      addr_load = 1'b0;
      addr_step = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               rd_d      = cmd_rd;
               lane_d    = '0;
               addr_load = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_REQ: begin
            // Request and address stay put until the memory grants.
            if (mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // Write-port fields are registered here so they are stable for
            // the whole WRITE cycle. rvalid seen in any other state is a
            // stale response and is dropped.
            if (mem_rvalid) begin
               word_d   = mem_rdata;
               wr_row_d = rd_q;
               wr_col_d = lane_q;
               state_d  = S_WRITE;
            end
         end
         S_WRITE: begin
            if (lane_q == LAST_LANE) begin
               state_d = S_DONE;
            end else begin
               lane_d    = lane_q + LANE_W'(1);
               addr_step = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         lane_q   <= '0;
         rd_q     <= '0;
         word_q   <= '0;
         wr_row_q <= '0;
         wr_col_q <= '0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         rd_q     <= rd_d;
         word_q   <= word_d;
         wr_row_q <= wr_row_d;
         wr_col_q <= wr_col_d;
      end
   end

   vload_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .load   (addr_load),
      .step   (addr_step),
      .base   (cmd_addr),
      .stride (stride_in),
      .addr   (mem_addr)
   );

   // Control outputs decode only the registered state.
   assign cmd_ready       = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign mem_req         = (state_q == S_REQ);
   assign writeEnable     = (state_q == S_WRITE);
   assign mem_load_enable = (state_q == S_WRITE);
   assign done            = (state_q == S_DONE);

   assign writeAddressR = wr_row_q;
   assign writeAddressC = wr_col_q;
   assign writeData     = {{(VREG_W - WORD_W){1'b0}}, word_q};

endmodule

// File: tb/tb_vector_load_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_load_unit
// Scoreboard bench: each issued command pushes its expected memory
// addresses, lane writes and completion latency into queues; a monitor pops
// and compares whenever the DUT requests memory, writes a lane or pulses
// done. A responder models memory grant/response timing.
// Define VLOAD_STRIDE_EN to also exercise the stride option.
// -----------------------------------------------------------------------------
module tb_vector_load_unit;
   import vload_pkg::*;

   logic         clk;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [15:0]  cmd_addr;
   logic [3:0]   cmd_rd;
   logic [15:0]  cmd_stride;
   logic         mem_req;
   logic [15:0]  mem_addr;
   logic         mem_gnt;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         writeEnable;
   logic         mem_load_enable;
   logic [3:0]   writeAddressR;
   logic [1:0]   writeAddressC;
   logic [127:0] writeData;
   logic         busy;
   logic         done;

   vector_load_unit #(
      .ADDR_W (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_rd          (cmd_rd),
`ifdef VLOAD_STRIDE_EN
      .cmd_stride      (cmd_stride),
`endif
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_gnt         (mem_gnt),
      .mem_rvalid      (mem_rvalid),
      .mem_rdata       (mem_rdata),
      .writeEnable     (writeEnable),
      .mem_load_enable (mem_load_enable),
      .writeAddressR   (writeAddressR),
      .writeAddressC   (writeAddressC),
      .writeData       (writeData),
      .busy            (busy),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------
   // Scoreboard state
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic [3:0]  r;
      logic [1:0]  c;
      logic [31:0] w;
   } wr_t;

   logic [15:0] exp_addr_q [$];
   wr_t         exp_wr_q   [$];
   int          exp_lat_q  [$];
   logic [31:0] rdata_q    [$];

   int n_checks = 0;
   int n_pass   = 0;

   int gnt_delay = 0;   // cycles mem_gnt stays low per request
   int rv_delay  = 1;   // cycles from grant to rvalid
   int grant_cnt = 0;
   int acc_cyc   = 0;
   int done_cyc  = 0;
   bit held_at_done = 1'b0;

   logic [15:0] va [4];
   logic [31:0] vw [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------------------------------------------------------------
   // Memory responder
   // ---------------------------------------------------------------------
   initial begin : responder
      int  req_cnt;
      int  rv_left;
      bit  pending;
      req_cnt    = 0;
      rv_left    = 0;
      pending    = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pending) begin
            rv_left--;
            if (rv_left == 0) begin
               pending    = 1'b0;
               mem_rvalid = 1'b1;
               mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
            end
         end
         if (mem_req) begin
            if (req_cnt >= gnt_delay) begin
               mem_gnt = 1'b1;
               req_cnt = 0;
               pending = 1'b1;
               rv_left = rv_delay;
            end else begin
               mem_gnt = 1'b0;
               req_cnt++;
            end
         end else begin
            mem_gnt = (gnt_delay == 0);
            req_cnt = 0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (cmd_valid && cmd_ready) begin
               if (held_at_done) begin
                  check("accept_after_done", cyc, done_cyc + 1);
                  held_at_done = 1'b0;
               end
               acc_cyc = cyc;
            end
            if (mem_req) begin
               check("busy_in_req", busy, 1'b1);
               check("req_expected", exp_addr_q.size() > 0, 1'b1);
               if (exp_addr_q.size() > 0) begin
                  if (mem_gnt) begin
                     check("mem_addr", mem_addr, exp_addr_q.pop_front());
                     grant_cnt++;
                  end else begin
                     check("mem_addr_hold", mem_addr, exp_addr_q[0]);
                  end
               end
            end
            if (writeEnable) begin
               wr_t e;
               check("busy_in_write", busy, 1'b1);
               check("write_expected", exp_wr_q.size() > 0, 1'b1);
               if (exp_wr_q.size() > 0) begin
                  e = exp_wr_q.pop_front();
                  check("writeAddressR", writeAddressR, e.r);
                  check("writeAddressC", writeAddressC, e.c);
                  check("writeData", writeData, {96'b0, e.w});
                  check("mem_load_enable", mem_load_enable, 1'b1);
               end
            end
            if (done) begin
               int lat;
               check("busy_at_done", busy, 1'b1);
               check("done_expected", exp_lat_q.size() > 0, 1'b1);
               if (exp_lat_q.size() > 0) begin
                  lat = exp_lat_q.pop_front();
                  if (lat > 0) check("done_latency", cyc - acc_cyc, lat);
               end
               if (cmd_valid) begin
                  held_at_done = 1'b1;
                  done_cyc     = cyc;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers (called at posedge+1)
   // ---------------------------------------------------------------------
   task automatic issue(input logic [15:0] base, input logic [3:0] rd,
                        input logic [15:0] stride, input int lat);
      int  n;
      wr_t e;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         exp_addr_q.push_back(va[i]);
         e.r = rd;
         e.c = 2'(i);
         e.w = vw[i];
         exp_wr_q.push_back(e);
         rdata_q.push_back(vw[i]);
      end
      exp_lat_q.push_back(lat);
      cmd_valid  = 1'b1;
      cmd_addr   = base;
      cmd_rd     = rd;
      cmd_stride = stride;
      forever begin
         @(negedge clk);
         n++;
         if (cmd_ready || n >= 400) break;
      end
      check("accept_timeout", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_rd    = '0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_lat_q.size() != 0 || !cmd_ready) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_timeout", n < 500, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin : main
      int n;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_rd     = '0;
      cmd_stride = '0;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_writeEnable", writeEnable, 1'b0);
      check("rst_mem_load_enable", mem_load_enable, 1'b0);
      check("rst_writeAddressR", writeAddressR, 4'h0);
      check("rst_writeAddressC", writeAddressC, 2'h0);
      check("rst_writeData", writeData, 128'h0);
      check("rst_done", done, 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Contiguous load, minimum latency.
      gnt_delay = 0; rv_delay = 1;
      va = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
      vw = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      issue(16'h0010, 4'd5, 16'd1, 13);
      wait_idle();

      // Backpressure: grant after 3 low cycles, rvalid 3 cycles after grant.
      gnt_delay = 3; rv_delay = 3;
      va = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      vw = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
      issue(16'h0100, 4'd9, 16'd1, 33);
      wait_idle();

      // Address wrap.
      gnt_delay = 0; rv_delay = 1;
      va = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      vw = '{32'h0BAD_F00D, 32'hCAFE_0001, 32'h1234_5678, 32'h8765_4321};
      issue(16'hFFFE, 4'd3, 16'd1, 13);
      wait_idle();

`ifdef VLOAD_STRIDE_EN
      va = '{16'h0020, 16'h0024, 16'h0028, 16'h002C};
      vw = '{32'h0000_0020, 32'h0000_0024, 32'h0000_0028, 32'h0000_002C};
      issue(16'h0020, 4'd7, 16'd4, 13);
      wait_idle();

      va = '{16'h0055, 16'h0055, 16'h0055, 16'h0055};
      vw = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
      issue(16'h0055, 4'd8, 16'd0, 13);
      wait_idle();
`endif

      // Reset during WAIT of lane 2, then a stale rvalid.
      gnt_delay = 0; rv_delay = 3; grant_cnt = 0;
      va = '{16'h0200, 16'h0201, 16'h0202, 16'h0203};
      vw = '{32'h2000_0000, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003};
      issue(16'h0200, 4'd12, 16'd1, -1);
      n = 0;
      while (grant_cnt < 3 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("lane2_grant_seen", grant_cnt, 3);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_mem_req", mem_req, 1'b0);
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_busy", busy, 1'b0);
      exp_addr_q.delete();
      exp_wr_q.delete();
      exp_lat_q.delete();
      @(negedge clk);
      #2;
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("postrst_cmd_ready", cmd_ready, 1'b1);
      check("postrst_busy", busy, 1'b0);
      rdata_q.delete();
      rv_delay = 1;
      @(posedge clk);
      #1;
      va = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};
      vw = '{32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003};
      issue(16'h0300, 4'd12, 16'd1, 13);
      wait_idle();

      // Command gating: B held valid while A runs.
      va = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
      vw = '{32'h4000_00A0, 32'h4000_00A1, 32'h4000_00A2, 32'h4000_00A3};
      issue(16'h0040, 4'd1, 16'd1, 13);
      va = '{16'h0080, 16'h0081, 16'h0082, 16'h0083};
      vw = '{32'h8000_00B0, 32'h8000_00B1, 32'h8000_00B2, 32'h8000_00B3};
      issue(16'h0080, 4'd2, 16'd1, 13);
      wait_idle();

      check("addr_queue_drained", exp_addr_q.size(), 0);
      check("write_queue_drained", exp_wr_q.size(), 0);
      check("done_queue_drained", exp_lat_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
